// File: rtl/bus_receiver.sv
// ---------------------------------------------------------------------------
// bus_receiver
//   Receive-side counterpart of the register-file bus transmitter. Captures the
//   shared data bus on each load strobe into a small show-ahead FIFO and hands
//   the buffered bytes, in order, to a consumer over a valid/ready handshake.
//   This decouples bus-cycle timing from consumer timing.
//
// Optional feature (compile-time macro BUS_RECEIVER_OVF_EN):
//   defined   : o_overflow is a sticky flag, set whenever a byte is dropped
//               because the FIFO is full. Cleared by i_reset or i_flush.
//   undefined : o_overflow is tied to 0. Dropped bytes are still discarded.
//
// Parameters
//   WIDTH  data/bus width in bits
//   DEPTH  FIFO entries (power of two, >= 2)
//
// Ports
//   i_clk       clock, all state changes on the rising edge
//   i_reset     synchronous active-high reset
//   i_bus       shared data bus, sampled on a push
//   i_busLoad   push request: capture i_bus this cycle
//   i_flush     discard every buffered byte
//   o_data      head-of-FIFO byte, 0 when empty
//   o_valid     o_data holds a valid byte
//   i_ready     consumer accepts o_data when o_valid && i_ready
//   o_full      count == DEPTH
//   o_empty     count == 0
//   o_count     number of buffered bytes
//   o_overflow  sticky drop flag (see above)
// ---------------------------------------------------------------------------
module bus_receiver #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [WIDTH-1:0]         i_bus,
  input  logic                     i_busLoad,
  input  logic                     i_flush,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push;
  logic             pop;

  // Status is derived from the registered count, never from pointer
  // comparison, so full and empty cannot be confused when the pointers meet.
  assign o_count = count;
  assign o_empty = (count == '0);
  assign o_full  = (count == CW'(DEPTH));
  assign o_valid = !o_empty;

  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign pop  = o_valid && i_ready;
  assign push = i_busLoad && (!o_full || pop);

  // Show-ahead read: the head entry is muxed straight out, forced to 0 when
  // nothing is buffered so stale storage never leaks to the consumer.
  assign o_data = o_empty ? '0 : mem[rd_ptr];

  // NOTE: storage is deliberately left out of reset; only the pointers and
  // count define which entries are meaningful, so the array maps to plain RAM.
  always_ff @(posedge i_clk) begin
    if (!i_reset && !i_flush && push) begin
      mem[wr_ptr] <= i_bus;
    end
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (i_flush) begin
      // Flush outranks any push/pop requested in the same cycle.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers wrap implicitly through their AW-bit width.
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef BUS_RECEIVER_OVF_EN
  logic overflow_q;
  logic overflow_event;

  // A byte is dropped when a load arrives at a full FIFO with no pop.
  assign overflow_event = i_busLoad && !push;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      overflow_q <= 1'b0;
    end else if (overflow_event) begin
      overflow_q <= 1'b1;
    end
  end

  assign o_overflow = overflow_q;
`else
  assign o_overflow = 1'b0;
`endif

endmodule
